// File: rtl/issue_queue_if.sv
// Signal bundle between rename/writeback/branch unit and one functional-unit issue queue.
// master = upstream driver side, slave = the queue itself.
interface issue_queue_if #(
  parameter int NUM_ENTRIES = 8,
  parameter int WIDTH_IN    = 4,
  parameter int WIDTH_WR    = 4,
  parameter int PAYLOAD_W   = 64
);
  localparam int CNT_W = $clog2(NUM_ENTRIES) + 1;

  logic [WIDTH_IN-1:0]           IN_valid;
  logic [WIDTH_IN*7-1:0]         IN_sqN;
  logic [WIDTH_IN*7-1:0]         IN_tagA;
  logic [WIDTH_IN*7-1:0]         IN_tagB;
  logic [WIDTH_IN-1:0]           IN_availA;
  logic [WIDTH_IN-1:0]           IN_availB;
  logic [WIDTH_IN*7-1:0]         IN_tagDst;
  logic [WIDTH_IN*PAYLOAD_W-1:0] IN_payload;
  logic [WIDTH_WR-1:0]           IN_wbValid;
  logic [WIDTH_WR*7-1:0]         IN_wbTag;
  logic                          IN_branchTaken;
  logic [6:0]                    IN_branchSqN;
  logic                          IN_stall;

  logic                          OUT_stall;
  logic                          OUT_valid;
  logic [6:0]                    OUT_sqN;
  logic [6:0]                    OUT_tagA;
  logic [6:0]                    OUT_tagB;
  logic [6:0]                    OUT_tagDst;
  logic [PAYLOAD_W-1:0]          OUT_payload;
  logic [CNT_W-1:0]              OUT_freeCnt;

  modport master (
    output IN_valid, IN_sqN, IN_tagA, IN_tagB, IN_availA, IN_availB, IN_tagDst,
           IN_payload, IN_wbValid, IN_wbTag, IN_branchTaken, IN_branchSqN, IN_stall,
    input  OUT_stall, OUT_valid, OUT_sqN, OUT_tagA, OUT_tagB, OUT_tagDst,
           OUT_payload, OUT_freeCnt
  );

  modport slave (
    input  IN_valid, IN_sqN, IN_tagA, IN_tagB, IN_availA, IN_availB, IN_tagDst,
           IN_payload, IN_wbValid, IN_wbTag, IN_branchTaken, IN_branchSqN, IN_stall,
    output OUT_stall, OUT_valid, OUT_sqN, OUT_tagA, OUT_tagB, OUT_tagDst,
           OUT_payload, OUT_freeCnt
  );
endinterface

// File: rtl/issue_queue.sv
// Per-FU issue queue: holds renamed uops until both operands are woken up, then
// issues the oldest ready one per cycle through a stallable output register.
module issue_queue #(
  parameter int NUM_ENTRIES = 8,
  parameter int WIDTH_IN    = 4,
  parameter int WIDTH_WR    = 4,
  parameter int PAYLOAD_W   = 64
) (
  input  logic clk,
  input  logic rst,
  issue_queue_if.slave iq
);
  localparam int IDX_W = $clog2(NUM_ENTRIES);
  localparam int CNT_W = IDX_W + 1;

  typedef logic [6:0] tag_t;

  logic [NUM_ENTRIES-1:0] valid;
  logic [NUM_ENTRIES-1:0] validNext;
  logic [NUM_ENTRIES-1:0] availA;
  logic [NUM_ENTRIES-1:0] availB;
  tag_t                   sqN     [NUM_ENTRIES];
  tag_t                   tagA    [NUM_ENTRIES];
  tag_t                   tagB    [NUM_ENTRIES];
  tag_t                   tagDst  [NUM_ENTRIES];
  logic [PAYLOAD_W-1:0]   payload [NUM_ENTRIES];

  logic [CNT_W-1:0]       freeCnt;
  logic [CNT_W-1:0]       usedNext;
  logic                   outValid;
  tag_t                   outSqN;
  tag_t                   outTagA;
  tag_t                   outTagB;
  tag_t                   outTagDst;
  logic [PAYLOAD_W-1:0]   outPayload;

  logic                   found;
  logic [IDX_W-1:0]       pickIdx;
  logic                   doPick;
  logic                   doEnq;
  logic                   stallDispatch;
  logic [IDX_W-1:0]       laneSlot [WIDTH_IN];
  logic [NUM_ENTRIES-1:0] taken;

  function automatic logic wbHit(input tag_t tag);
    logic hit;
    hit = 1'b0;
    for (int w = 0; w < WIDTH_WR; w++)
      if (iq.IN_wbValid[w] && iq.IN_wbTag[w*7 +: 7] == tag) hit = 1'b1;
    return hit;
  endfunction

  // True when a is strictly younger than b under 7-bit wrap-around ordering.
  function automatic logic isYounger(input tag_t a, input tag_t b);
    tag_t d;
    d = a - b;
    return (d != 7'd0) && !d[6];
  endfunction

  assign stallDispatch = freeCnt < CNT_W'(WIDTH_IN);
  assign doEnq         = !iq.IN_branchTaken && !stallDispatch;
  assign doPick        = found && (!iq.IN_stall || !outValid) && !iq.IN_branchTaken;

  always_comb begin
    found   = 1'b0;
    pickIdx = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (valid[i] && availA[i] && availB[i]) begin
        if (!found || isYounger(sqN[pickIdx], sqN[i])) begin
          found   = 1'b1;
          pickIdx = IDX_W'(i);
        end
      end
    end
  end

  // Slots freed by this cycle's pick are deliberately not offered to dispatch.
  always_comb begin
    logic got;
    taken = valid;
    got   = 1'b0;
    for (int l = 0; l < WIDTH_IN; l++) begin
      laneSlot[l] = '0;
      got         = 1'b0;
      if (iq.IN_valid[l]) begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
          if (!got && !taken[i]) begin
            laneSlot[l] = IDX_W'(i);
            taken[i]    = 1'b1;
            got         = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    validNext = valid;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (iq.IN_branchTaken && isYounger(sqN[i], iq.IN_branchSqN)) validNext[i] = 1'b0;
      if (doPick && pickIdx == IDX_W'(i)) validNext[i] = 1'b0;
    end
    if (doEnq)
      for (int l = 0; l < WIDTH_IN; l++)
        if (iq.IN_valid[l]) validNext[laneSlot[l]] = 1'b1;
    usedNext = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) usedNext = usedNext + CNT_W'(validNext[i]);
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (!tagA[i][6] && wbHit(tagA[i])) availA[i] <= 1'b1;
      if (!tagB[i][6] && wbHit(tagB[i])) availB[i] <= 1'b1;
    end
    if (doEnq) begin
      for (int l = 0; l < WIDTH_IN; l++) begin
        if (iq.IN_valid[l]) begin
          sqN[laneSlot[l]]     <= iq.IN_sqN[l*7 +: 7];
          tagA[laneSlot[l]]    <= iq.IN_tagA[l*7 +: 7];
          tagB[laneSlot[l]]    <= iq.IN_tagB[l*7 +: 7];
          tagDst[laneSlot[l]]  <= iq.IN_tagDst[l*7 +: 7];
          payload[laneSlot[l]] <= iq.IN_payload[l*PAYLOAD_W +: PAYLOAD_W];
          availA[laneSlot[l]]  <= iq.IN_availA[l] | iq.IN_tagA[l*7+6] | wbHit(iq.IN_tagA[l*7 +: 7]);
          availB[laneSlot[l]]  <= iq.IN_availB[l] | iq.IN_tagB[l*7+6] | wbHit(iq.IN_tagB[l*7 +: 7]);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid      <= '0;
      freeCnt    <= CNT_W'(NUM_ENTRIES);
      outValid   <= 1'b0;
      outSqN     <= '0;
      outTagA    <= '0;
      outTagB    <= '0;
      outTagDst  <= '0;
      outPayload <= '0;
    end else begin
      valid   <= validNext;
      freeCnt <= CNT_W'(NUM_ENTRIES) - usedNext;
      if (iq.IN_branchTaken) begin
        if (outValid && isYounger(outSqN, iq.IN_branchSqN)) outValid <= 1'b0;
      end else if (doPick) begin
        outValid   <= 1'b1;
        outSqN     <= sqN[pickIdx];
        outTagA    <= tagA[pickIdx];
        outTagB    <= tagB[pickIdx];
        outTagDst  <= tagDst[pickIdx];
        outPayload <= payload[pickIdx];
      end else if (!iq.IN_stall) begin
        outValid <= 1'b0;
      end
    end
  end

  assign iq.OUT_stall   = stallDispatch;
  assign iq.OUT_valid   = outValid;
  assign iq.OUT_sqN     = outSqN;
  assign iq.OUT_tagA    = outTagA;
  assign iq.OUT_tagB    = outTagB;
  assign iq.OUT_tagDst  = outTagDst;
  assign iq.OUT_payload = outPayload;
  assign iq.OUT_freeCnt = freeCnt;
endmodule
